// File: rtl/bram_fifo_pkg.sv
// Shared sizing constants for the BRAM-backed FWFT FIFO controller.
// The top module optionally adds level/almost_full when BRAM_FIFO_COUNT_EN is defined.
package bram_fifo_pkg;
  localparam int ADDR_W_DEFAULT     = 13;
  localparam int DATA_W_DEFAULT     = 2;
  localparam int DEPTH              = 2 ** ADDR_W_DEFAULT;
  localparam int SKID_DEPTH         = 2;
  localparam int ALMOST_FULL_MARGIN = 16;
endpackage

// File: rtl/bram_fifo_ctrl_8192x2_skid.sv
// fifo_skid2: two-entry registered output FIFO; entry 0 is always the head so
// dout comes straight from a flop.
module fifo_skid2
  import bram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [1:0]        count
);
  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic [1:0] wr_idx;

  // A simultaneous pop shifts everything down, so the new word lands one slot lower.
  assign wr_idx = count_reg - {1'b0, pop};

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (pop && !push) begin
      count_next = count_reg - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
    logic [DATA_W-1:0] q;
    if (gi < SKID_DEPTH - 1) begin : g_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (push && (wr_idx == 2'(gi))) begin
          q <= din;
        end else if (pop) begin
          q <= g_entry[gi+1].q;
        end
      end
    end else begin : g_last
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (push && (wr_idx == 2'(gi))) begin
          q <= din;
        end
      end
    end
  end

  assign dout  = g_entry[0].q;
  assign valid = (count_reg != 2'd0);
  assign count = count_reg;
endmodule

// File: rtl/bram_fifo_ctrl_8192x2.sv
// FWFT FIFO controller driving an external BRAM_8192x2 (port 0 write, port 1 read).
// Define BRAM_FIFO_COUNT_EN to add the level and almost_full outputs.
module bram_fifo_ctrl_8192x2
  import bram_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] A0,
  output logic [DATA_W-1:0] D0,
  output logic              WE0,
  output logic [DATA_W-1:0] WEM0,
  output logic              CE0,
  input  logic [DATA_W-1:0] Q0,
  output logic [ADDR_W-1:0] A1,
  output logic [DATA_W-1:0] D1,
  output logic              WE1,
  output logic [DATA_W-1:0] WEM1,
  output logic              CE1,
  input  logic [DATA_W-1:0] Q1
`ifdef BRAM_FIFO_COUNT_EN
  ,
  output logic [ADDR_W+1:0] level,
  output logic              almost_full
`endif
);
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   bram_cnt_reg;
  logic [ADDR_W:0]   bram_cnt_next;
  logic              rd_pend_reg;
  logic              in_ready_reg;
  logic              push;
  logic              pop;
  logic              issue;
  logic [1:0]        skid_cnt;
  logic [2:0]        skid_claim;
  logic              unused_q0;

  assign push = in_valid & in_ready_reg;
  assign pop  = out_valid & out_ready;

  // Slots already spoken for once this cycle's pop leaves; issuing keeps it <= SKID_DEPTH.
  assign skid_claim = {1'b0, skid_cnt} + {2'b00, rd_pend_reg} - {2'b00, pop};
  assign issue      = (bram_cnt_reg != '0) && (skid_claim < 3'(SKID_DEPTH));

  always_comb begin
    bram_cnt_next = bram_cnt_reg;
    if (push && !issue) begin
      bram_cnt_next = bram_cnt_reg + (ADDR_W+1)'(1);
    end else if (issue && !push) begin
      bram_cnt_next = bram_cnt_reg - (ADDR_W+1)'(1);
    end
  end

  // in_ready is held low through reset, so it is a flop tracking the next count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      bram_cnt_reg <= '0;
      rd_pend_reg  <= 1'b0;
      in_ready_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (issue) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
      bram_cnt_reg <= bram_cnt_next;
      rd_pend_reg  <= issue;
      in_ready_reg <= (bram_cnt_next != DEPTH_CNT);
    end
  end

  // Q1 is only looked at while a read is pending, so a reset drops any in-flight word.
  fifo_skid2 #(.DATA_W(DATA_W)) u_skid (
    .clk   (CLK),
    .rst   (RST),
    .push  (rd_pend_reg),
    .din   (Q1),
    .pop   (pop),
    .dout  (out_data),
    .valid (out_valid),
    .count (skid_cnt)
  );

  assign in_ready  = in_ready_reg;
  assign A0        = wr_ptr_reg;
  assign D0        = in_data;
  assign WE0       = push;
  assign CE0       = push;
  assign WEM0      = '1;
  assign A1        = rd_ptr_reg;
  assign D1        = '0;
  assign WE1       = 1'b0;
  assign WEM1      = '0;
  assign CE1       = issue;
  assign unused_q0 = ^Q0;

`ifdef BRAM_FIFO_COUNT_EN
  localparam logic [ADDR_W:0] AF_THRESH = DEPTH_CNT - (ADDR_W+1)'(ALMOST_FULL_MARGIN);
  logic [ADDR_W+1:0] level_reg;

  // Total occupancy only moves on external handshakes; issue/return shuffle words internally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level_reg <= '0;
    end else if (push && !pop) begin
      level_reg <= level_reg + (ADDR_W+2)'(1);
    end else if (pop && !push) begin
      level_reg <= level_reg - (ADDR_W+2)'(1);
    end
  end

  assign level       = level_reg;
  assign almost_full = (bram_cnt_reg >= AF_THRESH);
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl_8192x2.sv
// Randomised self-checking bench for bram_fifo_ctrl_8192x2 with a behavioural BRAM
// and a queue-based reference model; BRAM_FIFO_COUNT_EN enables the level checks.
`timescale 1ns/1ps
module tb_bram_fifo_ctrl_8192x2;
  localparam int AW = 13;
  localparam int DW = 2;
  localparam int DEPTH_TB = 8192;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] A0, A1;
  logic [DW-1:0] D0, D1, WEM0, WEM1, Q0, Q1;
  logic          WE0, CE0, WE1, CE1;
`ifdef BRAM_FIFO_COUNT_EN
  logic [AW+1:0] level;
  logic          almost_full;
`endif

  bram_fifo_ctrl_8192x2 dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0), .CE0(CE0), .Q0(Q0),
    .A1(A1), .D1(D1), .WE1(WE1), .WEM1(WEM1), .CE1(CE1), .Q1(Q1)
`ifdef BRAM_FIFO_COUNT_EN
    , .level(level), .almost_full(almost_full)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural dual-port BRAM: synchronous write, 1-cycle registered read.
  logic [DW-1:0] bram_mem [DEPTH_TB];
  logic [DW-1:0] q1_reg = '0;
  initial for (int i = 0; i < DEPTH_TB; i++) bram_mem[i] = '0;
  always @(posedge CLK) begin
    if (CE0 && WE0) bram_mem[A0] <= D0;
    if (CE1) q1_reg <= bram_mem[A1];
  end
  assign Q1 = q1_reg;
  assign Q0 = '0;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] model_q [$];
  bit did_push, did_pop;
  logic [DW-1:0] exp_d;

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
    @(posedge CLK); #1;
    in_valid = v; in_data = d; out_ready = r;
  endtask

  task automatic sample();
    @(negedge CLK);
    did_push = in_valid && in_ready;
    did_pop  = out_valid && out_ready;
    if (did_push) model_q.push_back(in_data);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 2'b00 || WE0 !== 1'b0 || CE1 !== 1'b0)
      begin failures++; $display("FAIL reset_outputs: got in_ready=%b out_valid=%b out_data=%b WE0=%b CE1=%b, want 0 0 00 0 0", in_ready, out_valid, out_data, WE0, CE1); end
    checks++;
    if (A0 !== 13'd0 || A1 !== 13'd0 || WEM0 !== 2'b11 || WE1 !== 1'b0)
      begin failures++; $display("FAIL reset_ports: got A0=%0d A1=%0d WEM0=%b WE1=%b, want 0 0 11 0", A0, A1, WEM0, WE1); end
    @(posedge CLK); #1; RST = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin failures++; $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid); end
    $display("txn reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_single();
    drive(1'b1, 2'b10, 1'b1); @(negedge CLK);
    checks++;
    if (WE0 !== 1'b1 || CE0 !== 1'b1 || A0 !== 13'd0 || D0 !== 2'b10 || CE1 !== 1'b0)
      begin failures++; $display("FAIL single_c0: got WE0=%b CE0=%b A0=%0d D0=%b CE1=%b, want 1 1 0 10 0", WE0, CE0, A0, D0, CE1); end
    drive(1'b0, 2'b00, 1'b1); @(negedge CLK);
    checks++;
    if (CE1 !== 1'b1 || A1 !== 13'd0 || WE0 !== 1'b0)
      begin failures++; $display("FAIL single_c1: got CE1=%b A1=%0d WE0=%b, want 1 0 0", CE1, A1, WE0); end
    drive(1'b0, 2'b00, 1'b1); @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0)
      begin failures++; $display("FAIL single_c2: got out_valid=%b, want 0", out_valid); end
    drive(1'b0, 2'b00, 1'b1); @(negedge CLK);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'b10)
      begin failures++; $display("FAIL single_c3: got out_valid=%b out_data=%b, want 1 10", out_valid, out_data); end
    drive(1'b0, 2'b00, 1'b1); @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0)
      begin failures++; $display("FAIL single_c4: got out_valid=%b, want 0", out_valid); end
    $display("txn single: word 10 seen at cycle 3");
  endtask

  task automatic test_fill_drain();
    int acc = 0, pops = 0, cyc = 0;
    model_q.delete();
    while (acc < DEPTH_TB + 2 && cyc < 10000) begin
      drive(1'b1, 2'(acc % 4), 1'b0); sample();
      if (did_push) acc++;
      cyc++;
    end
    checks++;
    if (acc != DEPTH_TB + 2)
      begin failures++; $display("FAIL fill_accepted: got %0d words, want %0d", acc, DEPTH_TB + 2); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 1'b0); sample();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || did_push)
        begin failures++; $display("FAIL full_hold: got in_ready=%b out_valid=%b, want 0 1", in_ready, out_valid); end
    end
    cyc = 0;
    while (pops < DEPTH_TB + 2 && cyc < 10000) begin
      drive(1'b0, 2'b00, 1'b1); sample();
      if (did_pop) begin
        pops++;
        checks++;
        if (model_q.size() == 0) begin failures++; $display("FAIL drain_extra: got data=%b, want no word", out_data); end
        else begin
          exp_d = model_q.pop_front();
          if (out_data !== exp_d) begin failures++; $display("FAIL drain_data[%0d]: got %b, want %b", pops - 1, out_data, exp_d); end
        end
      end
      cyc++;
    end
    repeat (3) begin drive(1'b0, 2'b00, 1'b1); sample(); end
    checks++;
    if (pops != DEPTH_TB + 2 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL drain_end: got pops=%0d out_valid=%b in_ready=%b, want %0d 0 1", pops, out_valid, in_ready, DEPTH_TB + 2); end
    $display("txn fill_drain: accepted=%0d popped=%0d", acc, pops);
  endtask

  task automatic test_back_to_back();
    int first_pop = -1, stalls = 0, cyc = 0;
    bit wrap0 = 0, wrap1 = 0, prev_we = 0, prev_ce = 0;
    logic [AW-1:0] prev_a0 = '0, prev_a1 = '0;
    model_q.delete();
    for (int c = 0; c < 8400; c++) begin
      drive(1'b1, 2'($urandom), 1'b1); sample();
      if (did_pop) begin
        checks++;
        if (model_q.size() == 0) begin failures++; $display("FAIL b2b_extra: got data=%b, want no word", out_data); end
        else begin
          exp_d = model_q.pop_front();
          if (out_data !== exp_d) begin failures++; $display("FAIL b2b_data: got %b, want %b", out_data, exp_d); end
        end
        if (first_pop < 0) first_pop = c;
      end
      if ((first_pop >= 0 && !did_pop) || !did_push) stalls++;
      if (WE0 && prev_we && prev_a0 == 13'd8191 && A0 == 13'd0) wrap0 = 1;
      if (CE1 && prev_ce && prev_a1 == 13'd8191 && A1 == 13'd0) wrap1 = 1;
      prev_we = WE0; prev_ce = CE1; prev_a0 = A0; prev_a1 = A1;
    end
    checks++;
    if (first_pop != 3) begin failures++; $display("FAIL b2b_latency: got first pop at %0d, want 3", first_pop); end
    checks++;
    if (stalls != 0 || !wrap0 || !wrap1)
      begin failures++; $display("FAIL b2b_stream: got stalls=%0d wrap0=%b wrap1=%b, want 0 1 1", stalls, wrap0, wrap1); end
    while (model_q.size() > 0 && cyc < 50) begin
      drive(1'b0, 2'b00, 1'b1); sample();
      if (did_pop) begin
        checks++;
        exp_d = model_q.pop_front();
        if (out_data !== exp_d) begin failures++; $display("FAIL b2b_tail: got %b, want %b", out_data, exp_d); end
      end
      cyc++;
    end
    checks++;
    if (model_q.size() != 0) begin failures++; $display("FAIL b2b_drain: got %0d words left, want 0", model_q.size()); end
    $display("txn back_to_back: first_pop=%0d stalls=%0d", first_pop, stalls);
  endtask

  task automatic test_random();
    int acc = 0, bc = 0, sk = 0, cyc = 0, bad_ce = 0, bad_sk = 0;
    bit ce_prev = 0;
    model_q.delete();
    while ((acc < 20000 || model_q.size() > 0) && cyc < 60000) begin
      drive((acc < 20000) && ($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 1)));
      sample();
      checks++;
      if (CE1 && bc == 0) begin
        bad_ce++; failures++; $display("FAIL rand_ce1_empty: got CE1=1 with bram count 0 at cycle %0d, want CE1=0", cyc);
      end
      checks++;
      if (out_valid !== (sk != 0)) begin
        failures++; $display("FAIL rand_out_valid: got %b, want %b at cycle %0d", out_valid, (sk != 0), cyc);
      end
      bc = bc + int'(WE0) - int'(CE1);
      sk = sk + int'(ce_prev) - int'(did_pop);
      ce_prev = CE1;
      checks++;
      if (sk > 2 || sk < 0) begin
        bad_sk++; failures++; $display("FAIL rand_skid_bound: got skid=%0d, want 0..2", sk);
      end
      if (did_push) acc++;
      if (did_pop) begin
        checks++;
        if (model_q.size() == 0) begin failures++; $display("FAIL rand_extra: got data=%b, want no word", out_data); end
        else begin
          exp_d = model_q.pop_front();
          if (out_data !== exp_d) begin failures++; $display("FAIL rand_data: got %b, want %b", out_data, exp_d); end
        end
      end
      cyc++;
    end
    checks++;
    if (acc != 20000 || model_q.size() != 0)
      begin failures++; $display("FAIL rand_budget: got accepted=%0d left=%0d, want 20000 0", acc, model_q.size()); end
    $display("txn random: words=%0d cycles=%0d bad_ce=%0d bad_skid=%0d", acc, cyc, bad_ce, bad_sk);
  endtask

  task automatic test_reset_midflight();
    logic [DW-1:0] pat [5];
    bit found = 0;
    int cyc = 0;
    pat[0] = 2'b11; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b10; pat[4] = 2'b11;
    for (int i = 0; i < 5; i++) begin drive(1'b1, pat[i], 1'b0); @(negedge CLK); end
    repeat (3) begin drive(1'b0, 2'b00, 1'b0); @(negedge CLK); end
    drive(1'b0, 2'b00, 1'b1); @(negedge CLK);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'b11 || CE1 !== 1'b1)
      begin failures++; $display("FAIL mid_pop_issue: got out_valid=%b out_data=%b CE1=%b, want 1 11 1", out_valid, out_data, CE1); end
    @(posedge CLK); #1; RST = 1'b1; out_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || CE1 !== 1'b0 || WE0 !== 1'b0)
      begin failures++; $display("FAIL mid_reset: got out_valid=%b in_ready=%b CE1=%b WE0=%b, want 0 0 0 0", out_valid, in_ready, CE1, WE0); end
    @(posedge CLK); #1; RST = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin failures++; $display("FAIL mid_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid); end
    drive(1'b1, 2'b01, 1'b1); @(negedge CLK);
    checks++;
    if (WE0 !== 1'b1 || A0 !== 13'd0)
      begin failures++; $display("FAIL mid_wr_ptr: got WE0=%b A0=%0d, want 1 0", WE0, A0); end
    while (!found && cyc < 10) begin
      drive(1'b0, 2'b00, 1'b1); @(negedge CLK);
      if (out_valid) begin
        found = 1;
        checks++;
        if (out_data !== 2'b01) begin failures++; $display("FAIL mid_first_word: got %b, want 01", out_data); end
      end
      cyc++;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_timeout: got no out_valid in 10 cycles, want word 01"); end
    drive(1'b0, 2'b00, 1'b1); @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale: got out_valid=%b data=%b, want 0", out_valid, out_data); end
    $display("txn reset_midflight: first word after reset found=%b", found);
  endtask

`ifdef BRAM_FIFO_COUNT_EN
  task automatic test_count();
    int bc = 0, pushed = 0, cyc = 0;
    bit seen = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'($urandom), 1'b0); @(negedge CLK);
      if (in_valid && in_ready) pushed++;
      bc = bc + int'(WE0) - int'(CE1);
    end
    repeat (4) begin drive(1'b0, 2'b00, 1'b0); @(negedge CLK); bc = bc + int'(WE0) - int'(CE1); end
    checks++;
    if (level !== 15'd10) begin failures++; $display("FAIL count_level10: got %0d, want 10", level); end
    while (!seen && cyc < 8400) begin
      drive(1'b1, 2'($urandom), 1'b0); @(negedge CLK);
      checks++;
      if (almost_full !== (bc >= DEPTH_TB - 16))
        begin failures++; $display("FAIL count_almost_full: got %b at bram count %0d, want %b", almost_full, bc, (bc >= DEPTH_TB - 16)); end
      if (almost_full) begin
        seen = 1;
        checks++;
        if (bc != DEPTH_TB - 16) begin failures++; $display("FAIL count_af_point: got bram count %0d, want %0d", bc, DEPTH_TB - 16); end
      end
      if (in_valid && in_ready) pushed++;
      bc = bc + int'(WE0) - int'(CE1);
      cyc++;
    end
    drive(1'b0, 2'b00, 1'b0); @(negedge CLK);
    checks++;
    if (!seen || level !== 15'(pushed))
      begin failures++; $display("FAIL count_level_full: got seen=%b level=%0d, want 1 %0d", seen, level, pushed); end
    $display("txn count: pushed=%0d level=%0d", pushed, level);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_random();
    test_reset_midflight();
`ifdef BRAM_FIFO_COUNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
